// File: rtl/prog_loader.sv
// prog_loader: checks opcodes from field-level requests, encodes legal ones
// into 32-bit words and writes them from address 0; holds cpu_rst while loading.
//
// Ports:
//   clk, sys_rst        clock, async active-high reset
//   in_valid/in_ready   request handshake
//   in_oper..in_last    instruction fields and end-of-program flag
//   reload              pulse in RUN restarts loading
//   mem_we/addr/wdata   program-memory write port
//   cpu_rst             processor reset, high while loading
//   err_illegal         one-cycle pulse per rejected request
//   load_count          words written since the last load start
module prog_loader #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          sys_rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_oper,
    input  logic [4:0]    in_rdst,
    input  logic [4:0]    in_rsrc1,
    input  logic          in_imm_mode,
    input  logic [4:0]    in_rsrc2,
    input  logic [15:0]   in_imm,
    input  logic          in_last,
    input  logic          reload,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_rst,
    output logic          err_illegal,
    output logic [AW:0]   load_count
);

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

    logic [1:0]  state;
    logic        last_q;
    logic        mem_op;
    logic        legal;
    logic [31:0] enc;

    // Memory-access opcodes always carry an address in the immediate field.
    assign mem_op = (in_oper == 5'd13) || (in_oper == 5'd14) ||
                    (in_oper == 5'd15) || (in_oper == 5'd17);
    assign legal  = (in_oper <= 5'd11) || mem_op;

    assign enc = (mem_op || in_imm_mode)
               ? {in_oper, in_rdst, in_rsrc1, 1'b1, in_imm}
               : {in_oper, in_rdst, in_rsrc1, 1'b0, in_rsrc2, 11'd0};

    // Decoded straight from state so sys_rst clears them without an edge.
    assign in_ready = (state == S_LOAD);
    assign mem_we   = (state == S_WRITE);
    assign cpu_rst  = (state != S_RUN);

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= S_LOAD;
            last_q      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            err_illegal <= 1'b0;
            load_count  <= '0;
        end else begin
            err_illegal <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        if (legal) begin
                            mem_wdata <= enc;
                            last_q    <= in_last;
                            state     <= S_WRITE;
                        end else begin
                            err_illegal <= 1'b1;
                            if (in_last) begin
                                state <= S_RUN;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    mem_addr   <= mem_addr + 1'b1;
                    load_count <= load_count + 1'b1;
                    if (last_q || (load_count == LAST_IDX)) begin
                        state <= S_RUN;
                    end else begin
                        state <= S_LOAD;
                    end
                end
                S_RUN: begin
                    if (reload) begin
                        state      <= S_LOAD;
                        mem_addr   <= '0;
                        load_count <= '0;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table-driven vectors plus scoreboard of expected writes
// for prog_loader.
module tb_prog_loader;

    logic        clk;
    logic        sys_rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_oper;
    logic [4:0]  in_rdst;
    logic [4:0]  in_rsrc1;
    logic        in_imm_mode;
    logic [4:0]  in_rsrc2;
    logic [15:0] in_imm;
    logic        in_last;
    logic        reload;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        err_illegal;
    logic [4:0]  load_count;

    prog_loader #(.DEPTH(16), .AW(4)) dut (
        .clk(clk), .sys_rst(sys_rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_oper(in_oper), .in_rdst(in_rdst), .in_rsrc1(in_rsrc1),
        .in_imm_mode(in_imm_mode), .in_rsrc2(in_rsrc2), .in_imm(in_imm),
        .in_last(in_last), .reload(reload),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .err_illegal(err_illegal),
        .load_count(load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  oper;
        logic [4:0]  rdst;
        logic [4:0]  rsrc1;
        logic        mode;
        logic [4:0]  rsrc2;
        logic [15:0] imm;
        logic        last;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] word;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_addr = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!sys_rst && mem_we) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %h data %h",
                         mem_addr, mem_wdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                chk("wr_data", mem_wdata, e.word);
            end
        end
    end

    task automatic send(input vec_t v, input bit push);
        bit ok;
        @(negedge clk);
        in_oper     = v.oper;
        in_rdst     = v.rdst;
        in_rsrc1    = v.rsrc1;
        in_imm_mode = v.mode;
        in_rsrc2    = v.rsrc2;
        in_imm      = v.imm;
        in_last     = v.last;
        in_valid    = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                if (push && v.legal) begin
                    sb.push_back('{exp_addr, v.word});
                end
                if (v.legal) exp_addr = exp_addr + 4'd1;
                @(posedge clk);
                break;
            end
            @(negedge clk);
        end
        #1 in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept");
        end
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1 reload = 1'b0;
        @(negedge clk);
        chk("rl_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rl_ready", 32'(in_ready), 32'd1);
        chk("rl_addr", 32'(mem_addr), 32'd0);
        chk("rl_count", 32'(load_count), 32'd0);
        exp_addr = '0;
    endtask

    vec_t vecs[7];
    vec_t add_v;
    vec_t fill_v;

    initial begin
        vecs[0] = '{5'd1,  5'd5,  5'd0,  1'b1, 5'd0,  16'h00AB, 1'b0, 1'b1, 32'h094100AB};
        vecs[1] = '{5'd12, 5'd1,  5'd1,  1'b0, 5'd1,  16'h0000, 1'b0, 1'b0, 32'h0};
        vecs[2] = '{5'd13, 5'd0,  5'd5,  1'b0, 5'd0,  16'h0004, 1'b0, 1'b1, 32'h680B0004};
        vecs[3] = '{5'd16, 5'd2,  5'd2,  1'b1, 5'd0,  16'h1111, 1'b0, 1'b0, 32'h0};
        vecs[4] = '{5'd17, 5'd2,  5'd0,  1'b0, 5'd7,  16'h1234, 1'b0, 1'b1, 32'h88811234};
        vecs[5] = '{5'd11, 5'd31, 5'd31, 1'b0, 5'd31, 16'hFFFF, 1'b0, 1'b1, 32'h5FFEF800};
        vecs[6] = '{5'd31, 5'd0,  5'd0,  1'b0, 5'd0,  16'h0000, 1'b1, 1'b0, 32'h0};
        add_v   = '{5'd2,  5'd3,  5'd1,  1'b0, 5'd2,  16'h0000, 1'b1, 1'b1, 32'h10C21000};
        fill_v  = '{5'd3,  5'd1,  5'd2,  1'b1, 5'd0,  16'h5A5A, 1'b0, 1'b1, 32'h18455A5A};

        sys_rst = 1'b1;
        in_valid = 1'b0; in_oper = '0; in_rdst = '0; in_rsrc1 = '0;
        in_imm_mode = 1'b0; in_rsrc2 = '0; in_imm = '0; in_last = 1'b0;
        reload = 1'b0;

        @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_err", 32'(err_illegal), 32'd0);
        chk("rst_count", 32'(load_count), 32'd0);
        @(negedge clk);
        sys_rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            send(vecs[i], 1'b1);
            @(negedge clk);
            chk($sformatf("v%0d_err", i), 32'(err_illegal), 32'(!vecs[i].legal));
            chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(vecs[i].legal));
        end
        chk("tbl_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("tbl_ready", 32'(in_ready), 32'd0);
        chk("tbl_count", 32'(load_count), 32'd4);
        chk("tbl_addr", 32'(mem_addr), 32'd4);

        do_reload();
        send(add_v, 1'b1);
        @(negedge clk);
        chk("add_we", 32'(mem_we), 32'd1);
        chk("add_cpu_rst_hold", 32'(cpu_rst), 32'd1);
        @(negedge clk);
        chk("add_cpu_rst_drop", 32'(cpu_rst), 32'd0);
        chk("add_count", 32'(load_count), 32'd1);

        do_reload();
        for (int i = 0; i < 16; i++) begin
            sb.push_back('{4'(i), fill_v.word});
        end
        in_oper = fill_v.oper; in_rdst = fill_v.rdst; in_rsrc1 = fill_v.rsrc1;
        in_imm_mode = fill_v.mode; in_rsrc2 = fill_v.rsrc2;
        in_imm = fill_v.imm; in_last = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("fill_ready%0d", i), 32'(in_ready), 32'(i % 2 == 0));
            @(negedge clk);
        end
        chk("fill_run", 32'(cpu_rst), 32'd0);
        chk("fill_count", 32'(load_count), 32'd16);
        chk("fill_addr_wrap", 32'(mem_addr), 32'd0);
        repeat (3) @(negedge clk);
        chk("fill_no17", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        chk("fill_sb_empty", 32'(sb.size()), 32'd0);

        do_reload();
        send(add_v, 1'b1);
        @(negedge clk);
        @(negedge clk);
        do_reload();
        send(fill_v, 1'b1);
        @(negedge clk);
        @(negedge clk);
        send(fill_v, 1'b0);
        chk("mid_we_before", 32'(mem_we), 32'd1);
        #1 sys_rst = 1'b1;
        #1;
        chk("mid_we_async", 32'(mem_we), 32'd0);
        @(negedge clk);
        sys_rst = 1'b0;
        @(negedge clk);
        chk("mid_ready", 32'(in_ready), 32'd1);
        chk("mid_addr", 32'(mem_addr), 32'd0);
        chk("mid_count", 32'(load_count), 32'd0);
        chk("mid_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("mid_we_after", 32'(mem_we), 32'd0);

        repeat (2) @(negedge clk);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Instruction encoder and program loader that fills the processor's 16-entry program memory. It accepts field-level instruction requests over a valid/ready handshake and checks each opcode against the processor's instruction set. Legal requests are packed into the 32-bit instruction format and written sequentially from address 0. While loading, it holds the processor in reset through `cpu_rst`, and releases it once the program is complete.

## Interface
- `DEPTH`, 16, number of program-memory words; must be a power of two.
- `AW`, 4, program-memory address width; equals log2(`DEPTH`).
- `clk` in 1: sole clock, rising edge.
- `sys_rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: request valid.
- `in_ready` out 1: loader can accept a request.
- `in_oper` in 5: opcode.
- `in_rdst` in 5: destination register.
- `in_rsrc1` in 5: source register 1.
- `in_imm_mode` in 1: immediate-mode select.
- `in_rsrc2` in 5: source register 2.
- `in_imm` in 16: immediate value or data-memory address.
- `in_last` in 1: this request is the final instruction of the program.
- `reload` in 1: single-cycle pulse that restarts loading.
- `mem_we` out 1: program-memory write strobe.
- `mem_addr` out AW: program-memory write address.
- `mem_wdata` out 32: encoded instruction word.
- `cpu_rst` out 1: processor reset; high while loading.
- `err_illegal` out 1: one-cycle pulse when a request is rejected.
- `load_count` out AW+1: number of words written since the last load start.

## Operation
- FSM states: LOAD, WRITE, RUN.
- Reset values: state LOAD, `in_ready`=1, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_rst`=1, `err_illegal`=0, `load_count`=0.
- A request is accepted when `in_valid` & `in_ready` are high at a rising edge.
- Word encoding:
  - [31:27] = `in_oper`, [26:22] = `in_rdst`, [21:17] = `in_rsrc1`, [16] = `in_imm_mode`.
  - If `in_imm_mode`=1: [15:0] = `in_imm`.
  - If `in_imm_mode`=0: [15:11] = `in_rsrc2`, [10:0] = 0.
- Memory opcodes 01101, 01110, 01111 and 10001 always encode [16]=1 and [15:0]=`in_imm`, regardless of `in_imm_mode`.
- Legal opcodes: 00000–01011, 01101, 01110, 01111, 10001.
- Illegal opcodes: 01100, 10000, 10010–11111.
- LOAD, `in_ready`=1:
  - Legal accept: latch the word, go to WRITE.
  - Illegal accept: no write, `mem_addr` unchanged, pulse `err_illegal`. Go to RUN if `in_last`=1, otherwise stay in LOAD.
- WRITE, `in_ready`=0:
  - `mem_we`=1 for exactly one cycle, with `mem_addr` and `mem_wdata` stable.
  - On exit: `mem_addr` increments, wrapping modulo DEPTH, and `load_count` increments.
  - Go to RUN if the accepted request had `in_last`=1 or this is the DEPTH-th write; otherwise return to LOAD.
- RUN:
  - `cpu_rst`=0, `in_ready`=0; `in_valid` is ignored.
  - `reload`=1: go to LOAD with `cpu_rst`=1, `mem_addr`=0, `load_count`=0.
- `reload` is ignored in LOAD and WRITE.
- Unwritten entries are left untouched; the loader never pads memory.

## Timing
- Accept at edge T → `mem_we`=1 during cycle T+1 → `in_ready`=1 again at T+2. Peak throughput is one instruction per 2 cycles.
- `cpu_rst` falls in the cycle after the final write completes, or in the cycle after an illegal request accepted with `in_last`=1.
- `err_illegal` is high for the single cycle following the accept edge.
- `reload` sampled at edge T → `cpu_rst`=1 and `in_ready`=1 from cycle T+1.
- `sys_rst` asserted at any time, including mid-WRITE, forces all outputs to their reset values immediately. A write in progress is aborted with no strobe.
- After 16 writes, `load_count`=16 and `mem_addr` has wrapped to 0.

## Test plan
- Register add: oper=00010, rdst=3, rsrc1=1, imm_mode=0, rsrc2=2, last=1 → one `mem_we` at addr 0, wdata=0x10C21000; `cpu_rst` drops one cycle later; `load_count`=1.
- Immediate mov then storereg: mov (rdst=5, imm_mode=1, imm=0x00AB), then storereg (oper=01101, rsrc1=5, imm_mode=0, imm=0x0004, last=1):
  - addr 0 wdata=0x094100AB.
  - addr 1 wdata=0x680B0004 (bit16 forced to 1).
- Illegal opcode 01100 mid-program → `err_illegal` pulses once, no write; the next legal word still lands at the next sequential address.
- Full memory: 16 legal requests with `in_valid` held high and `in_last`=0 → 16 writes at addr 0..15, `in_ready` toggling 1/0; RUN entered after the 16th write with `load_count`=16; a 17th request is not accepted.
- RUN then `reload` pulse → `cpu_rst`=1 and `in_ready`=1 next cycle; the next request writes addr 0.
- Assert `sys_rst` during WRITE → `mem_we` drops without waiting for a clock edge; after release: state LOAD, addr 0, `load_count`=0, `cpu_rst`=1.
